// File: rtl/ovc_status_tracker_pkg.sv
// ---------------------------------------------------------------------------
// ovc_status_tracker_pkg
// Shared types for the output-VC status tracker.
//   CRDTw       : width of one per-VC initial-credit field from the neighbour
//   CREDITw     : width of the per-VC credit counter (capacity up to 15)
//   ovc_info_t  : per-VC status word published to the router output stage
//   OVC_INFO_w  : bit width of ovc_info_t
//   ovc_init_state_t : per-VC bring-up state
// ---------------------------------------------------------------------------
package ovc_status_tracker_pkg;

    localparam int CRDTw   = 4;
    localparam int CREDITw = 4;

    // MSB first: avalable, status, credit, full, nearly_full, empty
    typedef struct packed {
        logic               avalable;
        logic               status;
        logic [CREDITw-1:0] credit;
        logic               full;
        logic               nearly_full;
        logic               empty;
    } ovc_info_t;

    localparam int OVC_INFO_w = $bits(ovc_info_t);

    typedef enum logic [1:0] {
        OVC_CAPTURE,
        OVC_WAIT_REL,
        OVC_ACTIVE,
        OVC_DISABLED
    } ovc_init_state_t;

endpackage

// File: rtl/ovc_credit_counter.sv
// ---------------------------------------------------------------------------
// ovc_credit_counter
// Single output-VC bring-up FSM, downstream credit counter, allocation status
// and sticky credit-error flag. All published fields come from registers.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   credit_init_val       : initial credit offered by the neighbour
//   credit_release_en     : deferred-release strobe (rising edge is used)
//   hetero_ovc_presence   : 1 when this VC exists downstream
//   credit_in             : one returned credit
//   flit_sent             : one flit written, consumes a credit
//   ovc_is_allocated      : VC granted to a packet
//   ovc_is_released       : tail of owning packet sent
//   ovc_info              : packed ovc_info_t
//   credit_err            : sticky error (overflow, underflow, bad use, clamp)
// ---------------------------------------------------------------------------
module ovc_credit_counter
    import ovc_status_tracker_pkg::*;
#(
    parameter int CAP            = 4,
    parameter int NF_TH          = 1,
    parameter int OVC_ALLOC_MODE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CRDTw-1:0]      credit_init_val,
    input  logic                  credit_release_en,
    input  logic                  hetero_ovc_presence,
    input  logic                  credit_in,
    input  logic                  flit_sent,
    input  logic                  ovc_is_allocated,
    input  logic                  ovc_is_released,
    output logic [OVC_INFO_w-1:0] ovc_info,
    output logic                  credit_err
);

    // One extra bit so sums of two credit values cannot wrap before the
    // saturation compare.
    localparam int                 CW1   = CREDITw + 1;
    localparam logic [CW1-1:0]     CAP_W = CW1'(CAP);
    localparam logic [CREDITw-1:0] CAP_C = CREDITw'(CAP);
    localparam logic [CW1-1:0]     NF_W  = CW1'(NF_TH);

    ovc_init_state_t    state_q, state_d;
    logic [CREDITw-1:0] credit_q, credit_d;
    logic               status_q, status_d;
    logic               err_q, err_d;
    logic               rel_prev_q, rel_prev_d;

    logic               rel_rise;
    logic [CW1-1:0]     init_w, init_sat, wait_sum, rel_sum;
    logic [CREDITw-1:0] act_sum;
    logic               init_over, bad_use, underflow, overflow;
    logic               is_full, is_nf, is_empty;
    ovc_info_t          info;

    assign rel_rise = credit_release_en & ~rel_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= OVC_CAPTURE;
            credit_q   <= '0;
            status_q   <= 1'b0;
            err_q      <= 1'b0;
            rel_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            status_q   <= status_d;
            err_q      <= err_d;
            rel_prev_q <= rel_prev_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        status_d = status_q;
        err_d    = err_q;

        // The edge detector is held at 0 through CAPTURE so a release strobe
        // that is already high at capture still counts as an edge in the
        // first WAIT_REL cycle.
        rel_prev_d = (state_q == OVC_CAPTURE) ? 1'b0 : credit_release_en;

        init_w    = CW1'(credit_init_val);
        init_over = (init_w > CAP_W);
        init_sat  = init_over ? CAP_W : init_w;
        wait_sum  = CW1'(credit_q) + CW1'(credit_in);
        rel_sum   = init_sat + wait_sum;
        bad_use   = flit_sent | ovc_is_allocated;
        underflow = flit_sent & ~credit_in & (credit_q == '0);
        overflow  = credit_in & ~flit_sent & (credit_q == CAP_C);
        act_sum   = credit_q + CREDITw'(credit_in) - CREDITw'(flit_sent);

        case (state_q)
            OVC_CAPTURE: begin
                err_d = err_q | bad_use;
                if (!hetero_ovc_presence) begin
                    state_d  = OVC_DISABLED;
                    credit_d = '0;
                end else if (credit_init_val != '0) begin
                    state_d  = OVC_ACTIVE;
                    credit_d = init_sat[CREDITw-1:0];
                    err_d    = err_q | bad_use | init_over;
                end else begin
                    state_d  = OVC_WAIT_REL;
                end
            end

            OVC_WAIT_REL: begin
                err_d = err_q | bad_use;
                if (rel_rise) begin
                    state_d = OVC_ACTIVE;
                    if (rel_sum > CAP_W) begin
                        credit_d = CAP_C;
                        err_d    = 1'b1;
                    end else begin
                        credit_d = rel_sum[CREDITw-1:0];
                        err_d    = err_q | bad_use | init_over;
                    end
                end else if (wait_sum > CAP_W) begin
                    credit_d = CAP_C;
                    err_d    = 1'b1;
                end else begin
                    credit_d = wait_sum[CREDITw-1:0];
                end
            end

            OVC_ACTIVE: begin
                status_d = (status_q | ovc_is_allocated) & ~ovc_is_released;
                if (underflow) begin
                    credit_d = '0;
                    err_d    = 1'b1;
                end else if (overflow) begin
                    credit_d = CAP_C;
                    err_d    = 1'b1;
                end else begin
                    credit_d = act_sum;
                end
            end

            default: begin
                credit_d = '0;
                status_d = 1'b0;
                err_d    = err_q | bad_use;
            end
        endcase
    end

    // Published fields depend on registers only.
    always_comb begin
        is_full  = (credit_q == '0);
        is_empty = (credit_q == CAP_C);
        is_nf    = (CW1'(credit_q) <= NF_W);

        info             = '0;
        info.credit      = credit_q;
        info.status      = status_q;
        info.full        = is_full;
        info.nearly_full = is_nf;
        info.empty       = is_empty;
        info.avalable    = (state_q == OVC_ACTIVE) & ~status_q &
                           ((OVC_ALLOC_MODE != 0) ? ~is_full : ~is_nf);
    end

    assign ovc_info   = info;
    assign credit_err = err_q;

endmodule

// File: rtl/ovc_status_tracker.sv
// ---------------------------------------------------------------------------
// ovc_status_tracker
// Per-output-port tracker of downstream credit and allocation state for V
// output VCs. Each VC is an independent ovc_credit_counter; this level only
// picks the capacity and slices the buses.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   credit_init_val     : V x CRDTw initial credits
//   credit_release_en   : V deferred-release strobes
//   hetero_ovc_presence : V presence flags
//   credit_in           : V returned credits
//   flit_sent           : V flit-sent strobes
//   ovc_is_allocated    : V allocation grants
//   ovc_is_released     : V tail-sent releases
//   ovc_info            : V x OVC_INFO_w packed ovc_info_t
//   credit_err          : V sticky credit errors
// ---------------------------------------------------------------------------
module ovc_status_tracker
    import ovc_status_tracker_pkg::*;
#(
    parameter int V              = 4,
    parameter int B              = 4,
    parameter int LB             = 4,
    parameter int PORT_IS_ENDP   = 0,
    parameter int NF_TH          = 1,
    parameter int OVC_ALLOC_MODE = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [V*CRDTw-1:0]      credit_init_val,
    input  logic [V-1:0]            credit_release_en,
    input  logic [V-1:0]            hetero_ovc_presence,
    input  logic [V-1:0]            credit_in,
    input  logic [V-1:0]            flit_sent,
    input  logic [V-1:0]            ovc_is_allocated,
    input  logic [V-1:0]            ovc_is_released,
    output logic [V*OVC_INFO_w-1:0] ovc_info,
    output logic [V-1:0]            credit_err
);

    localparam int CAP = (PORT_IS_ENDP != 0) ? LB : B;

    for (genvar v = 0; v < V; v++) begin : g_vc
        ovc_credit_counter #(
            .CAP            (CAP),
            .NF_TH          (NF_TH),
            .OVC_ALLOC_MODE (OVC_ALLOC_MODE)
        ) u_ctr (
            .clk                 (clk),
            .reset               (reset),
            .credit_init_val     (credit_init_val[v*CRDTw +: CRDTw]),
            .credit_release_en   (credit_release_en[v]),
            .hetero_ovc_presence (hetero_ovc_presence[v]),
            .credit_in           (credit_in[v]),
            .flit_sent           (flit_sent[v]),
            .ovc_is_allocated    (ovc_is_allocated[v]),
            .ovc_is_released     (ovc_is_released[v]),
            .ovc_info            (ovc_info[v*OVC_INFO_w +: OVC_INFO_w]),
            .credit_err          (credit_err[v])
        );
    end

endmodule

// File: tb/tb_ovc_status_tracker.sv
// ---------------------------------------------------------------------------
// tb_ovc_status_tracker
// Directed scoreboard bench. Inputs change on the falling clock edge; the
// expected per-VC state after the next rising edge is queued at the same
// time. A monitor wakes after every rising clock edge or reset assertion and
// compares every queued entry against the DUT. Two instances share the
// inputs: one with OVC_ALLOC_MODE=1, one with OVC_ALLOC_MODE=0.
// ---------------------------------------------------------------------------
module tb_ovc_status_tracker;
    import ovc_status_tracker_pkg::*;

    localparam int V = 4;

    logic                    clk;
    logic                    reset;
    logic [V*CRDTw-1:0]      credit_init_val;
    logic [V-1:0]            credit_release_en;
    logic [V-1:0]            hetero_ovc_presence;
    logic [V-1:0]            credit_in;
    logic [V-1:0]            flit_sent;
    logic [V-1:0]            ovc_is_allocated;
    logic [V-1:0]            ovc_is_released;
    logic [V*OVC_INFO_w-1:0] info_m1, info_m0;
    logic [V-1:0]            err_m1, err_m0;

    typedef struct {
        string                 name;
        int                    inst;
        int                    vc;
        logic [OVC_INFO_w-1:0] info;
        logic                  err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    ovc_status_tracker #(.V(V), .OVC_ALLOC_MODE(1)) dut_m1 (
        .clk                 (clk),
        .reset               (reset),
        .credit_init_val     (credit_init_val),
        .credit_release_en   (credit_release_en),
        .hetero_ovc_presence (hetero_ovc_presence),
        .credit_in           (credit_in),
        .flit_sent           (flit_sent),
        .ovc_is_allocated    (ovc_is_allocated),
        .ovc_is_released     (ovc_is_released),
        .ovc_info            (info_m1),
        .credit_err          (err_m1)
    );

    ovc_status_tracker #(.V(V), .OVC_ALLOC_MODE(0)) dut_m0 (
        .clk                 (clk),
        .reset               (reset),
        .credit_init_val     (credit_init_val),
        .credit_release_en   (credit_release_en),
        .hetero_ovc_presence (hetero_ovc_presence),
        .credit_in           (credit_in),
        .flit_sent           (flit_sent),
        .ovc_is_allocated    (ovc_is_allocated),
        .ovc_is_released     (ovc_is_released),
        .ovc_info            (info_m0),
        .credit_err          (err_m0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [V-1:0] cin, input logic [V-1:0] fs,
                                 input logic [V-1:0] al, input logic [V-1:0] rl,
                                 input logic [V-1:0] re);
        credit_in         = cin;
        flit_sent         = fs;
        ovc_is_allocated  = al;
        ovc_is_released   = rl;
        credit_release_en = re;
    endtask

    // Fields in ovc_info_t order: avalable, status, credit, full, nearly_full, empty
    task automatic pushExpect(input string name, input int inst, input int vc,
                              input logic a, input logic s, input logic [3:0] c,
                              input logic f, input logic nf, input logic e,
                              input logic er);
        exp_t x;
        x.name = name;
        x.inst = inst;
        x.vc   = vc;
        x.info = {a, s, c, f, nf, e};
        x.err  = er;
        sb.push_back(x);
    endtask

    task automatic checkOutput(input exp_t x);
        logic [OVC_INFO_w-1:0] got_info;
        logic                  got_err;
        if (x.inst == 0) begin
            got_info = info_m1[x.vc*OVC_INFO_w +: OVC_INFO_w];
            got_err  = err_m1[x.vc];
        end else begin
            got_info = info_m0[x.vc*OVC_INFO_w +: OVC_INFO_w];
            got_err  = err_m0[x.vc];
        end
        checks++;
        if (got_info !== x.info) begin
            failures++;
            $display("[TB] FAIL %s inst%0d vc%0d ovc_info got=%b required=%b",
                     x.name, x.inst, x.vc, got_info, x.info);
        end
        checks++;
        if (got_err !== x.err) begin
            failures++;
            $display("[TB] FAIL %s inst%0d vc%0d credit_err got=%b required=%b",
                     x.name, x.inst, x.vc, got_err, x.err);
        end
    endtask

    // Monitor: drains the scoreboard after each clock edge or reset assertion.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            #1;
            while (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    initial begin
        reset               = 1'b0;
        credit_init_val     = 16'h4444;
        hetero_ovc_presence = 4'b1111;
        applyStimulus(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        for (int v = 0; v < V; v++) pushExpect("reset", 0, v, 0, 0, 4'd0, 1, 1, 0, 0);
        pushExpect("reset_m0", 1, 0, 0, 0, 4'd0, 1, 1, 0, 0);

        // Phase 1: capture 4 on all VCs
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int v = 0; v < V; v++) pushExpect("capture", 0, v, 1, 0, 4'd4, 0, 0, 1, 0);
        pushExpect("capture_m0", 1, 0, 1, 0, 4'd4, 0, 0, 1, 0);

        // Counting on VC0
        @(negedge clk); applyStimulus(4'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
        pushExpect("send1", 0, 0, 1, 0, 4'd3, 0, 0, 0, 0);
        @(negedge clk);
        pushExpect("send2", 0, 0, 1, 0, 4'd2, 0, 0, 0, 0);
        pushExpect("send2_m0", 1, 0, 1, 0, 4'd2, 0, 0, 0, 0);
        @(negedge clk);
        pushExpect("send3_nf", 0, 0, 1, 0, 4'd1, 0, 1, 0, 0);
        pushExpect("send3_m0_nf", 1, 0, 0, 0, 4'd1, 0, 1, 0, 0);
        @(negedge clk); applyStimulus(4'b0001, 4'b0001, 4'b0, 4'b0, 4'b0);
        pushExpect("in_and_send", 0, 0, 1, 0, 4'd1, 0, 1, 0, 0);
        @(negedge clk); applyStimulus(4'b0, 4'b0001, 4'b0, 4'b0, 4'b0);
        pushExpect("send4_full", 0, 0, 0, 0, 4'd0, 1, 1, 0, 0);
        @(negedge clk);
        pushExpect("underflow", 0, 0, 0, 0, 4'd0, 1, 1, 0, 1);
        pushExpect("vc1_untouched", 0, 1, 1, 0, 4'd4, 0, 0, 1, 0);

        // Status on VC2, counting on VC3
        @(negedge clk); applyStimulus(4'b0, 4'b0, 4'b0100, 4'b0100, 4'b0);
        pushExpect("alloc_rel_same", 0, 2, 1, 0, 4'd4, 0, 0, 1, 0);
        @(negedge clk); applyStimulus(4'b0, 4'b1000, 4'b0100, 4'b0, 4'b0);
        pushExpect("alloc", 0, 2, 0, 1, 4'd4, 0, 0, 1, 0);
        pushExpect("vc3_send1", 0, 3, 1, 0, 4'd3, 0, 0, 0, 0);
        @(negedge clk); applyStimulus(4'b0, 4'b1000, 4'b1000, 4'b0100, 4'b0);
        pushExpect("release", 0, 2, 1, 0, 4'd4, 0, 0, 1, 0);
        pushExpect("vc3_send2_alloc", 0, 3, 0, 1, 4'd2, 0, 0, 0, 0);
        @(negedge clk); applyStimulus(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        pushExpect("vc3_hold", 0, 3, 0, 1, 4'd2, 0, 0, 0, 0);

        // Reset mid-run: takes effect without a clock edge
        @(negedge clk);
        pushExpect("midrun_reset_vc3", 0, 3, 0, 0, 4'd0, 1, 1, 0, 0);
        pushExpect("midrun_reset_vc0", 0, 0, 0, 0, 4'd0, 1, 1, 0, 0);
        reset               = 1'b0;
        credit_init_val     = 16'h4403;
        hetero_ovc_presence = 4'b0011;

        // Phase 2: VC0 recaptures 3, VC1 deferred, VC2/VC3 absent
        @(negedge clk);
        reset = 1'b1;
        pushExpect("recapture", 0, 0, 1, 0, 4'd3, 0, 0, 0, 0);
        pushExpect("wait_rel", 0, 1, 0, 0, 4'd0, 1, 1, 0, 0);
        pushExpect("disabled2", 0, 2, 0, 0, 4'd0, 1, 1, 0, 0);
        pushExpect("disabled3", 0, 3, 0, 0, 4'd0, 1, 1, 0, 0);
        @(negedge clk); applyStimulus(4'b0010, 4'b1000, 4'b0, 4'b0, 4'b0);
        hetero_ovc_presence = 4'b1111;
        pushExpect("wait_acc1", 0, 1, 0, 0, 4'd1, 0, 1, 0, 0);
        pushExpect("disabled_sticky", 0, 2, 0, 0, 4'd0, 1, 1, 0, 0);
        pushExpect("disabled_send", 0, 3, 0, 0, 4'd0, 1, 1, 0, 1);
        pushExpect("vc0_indep", 0, 0, 1, 0, 4'd3, 0, 0, 0, 0);
        @(negedge clk); applyStimulus(4'b0010, 4'b0, 4'b0, 4'b0, 4'b0);
        pushExpect("wait_acc2", 0, 1, 0, 0, 4'd2, 0, 0, 0, 0);
        @(negedge clk); applyStimulus(4'b0, 4'b0, 4'b0, 4'b0, 4'b0010);
        credit_init_val = 16'h4423;
        pushExpect("release_load", 0, 1, 1, 0, 4'd4, 0, 0, 1, 0);
        @(negedge clk); applyStimulus(4'b0010, 4'b0, 4'b0, 4'b0, 4'b0010);
        pushExpect("overflow", 0, 1, 1, 0, 4'd4, 0, 0, 1, 1);
        pushExpect("vc0_no_err", 0, 0, 1, 0, 4'd3, 0, 0, 0, 0);

        // Phase 3: clamp on capture; release already high during CAPTURE
        @(negedge clk); applyStimulus(4'b0, 4'b0, 4'b0, 4'b0, 4'b0010);
        credit_init_val = 16'h4407;
        pushExpect("reset2_vc1", 0, 1, 0, 0, 4'd0, 1, 1, 0, 0);
        pushExpect("reset2_vc3", 0, 3, 0, 0, 4'd0, 1, 1, 0, 0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        pushExpect("clamp", 0, 0, 1, 0, 4'd4, 0, 0, 1, 1);
        pushExpect("wait_rel_high", 0, 1, 0, 0, 4'd0, 1, 1, 0, 0);
        @(negedge clk);
        credit_init_val = 16'h4427;
        pushExpect("release_high_at_capture", 0, 1, 1, 0, 4'd2, 0, 0, 0, 0);
        @(negedge clk); applyStimulus(4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        repeat (2) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
